// File: rtl/decoder_seq_if.sv
// Control/select bundle for decoder_seq: master drives the request side, slave returns registered selects.
interface decoder_seq_if #(
  parameter int unsigned N = 2
);
  localparam int unsigned W = 1 << N;

  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] din;
  logic         start;
  logic [W-1:0] dout;
  logic [N-1:0] idx;
  logic         busy;
  logic         done;

  modport master (
    output en, mode, din, start,
    input  dout, idx, busy, done
  );

  modport slave (
    input  en, mode, din, start,
    output dout, idx, busy, done
  );
endinterface

// File: rtl/decoder_seq.sv
// Registered N-to-2^N line decoder with direct decode, continuous scan and
// single-shot sweep (start/busy/done) modes.
module decoder_seq #(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL      = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  decoder_seq_if.slave bus
);
  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = $clog2(DWELL + 1);

  localparam logic [W-1:0]  INACTIVE  = {W{ACTIVE_LOW}};
  localparam logic [N-1:0]  LAST_IDX  = {N{1'b1}};
  localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL);
  localparam logic [CW-1:0] DWELL_ONE = CW'(1);

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_SCAN   = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state, w_state;
  logic [1:0]    r_prev_mode;
  logic [W-1:0]  r_dout, w_dout;
  logic [N-1:0]  r_idx, w_idx;
  logic [CW-1:0] r_dwell, w_dwell;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] k);
    return (W'(1) << k) ^ INACTIVE;
  endfunction

  // r_dwell counts cycles the current line has been driven (0 = not yet shown)
  always_comb begin
    w_state = r_state;
    w_dout  = INACTIVE;
    w_idx   = r_idx;
    w_dwell = r_dwell;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (bus.mode)
      M_DIRECT: begin
        w_state = S_IDLE;
        w_idx   = bus.din;
        if (bus.en) w_dout = onehot(bus.din);
      end
      M_SCAN: begin
        w_state = S_IDLE;
        if (r_prev_mode != M_SCAN) begin
          w_idx   = '0;
          w_dwell = bus.en ? DWELL_ONE : '0;
        end else if (bus.en) begin
          if (r_dwell == DWELL_MAX) begin
            w_idx   = r_idx + N'(1);
            w_dwell = DWELL_ONE;
          end else begin
            w_dwell = r_dwell + DWELL_ONE;
          end
        end
        if (bus.en) begin
          w_dout = onehot(w_idx);
          w_busy = 1'b1;
        end
      end
      M_SWEEP: begin
        case (r_state)
          S_IDLE: begin
            if (bus.en && bus.start) begin
              w_state = S_SWEEP;
              w_idx   = '0;
              w_dwell = DWELL_ONE;
              w_dout  = onehot('0);
              w_busy  = 1'b1;
            end
          end
          S_SWEEP: begin
            if (bus.en) begin
              if (r_dwell != DWELL_MAX) begin
                w_dwell = r_dwell + DWELL_ONE;
                w_dout  = onehot(r_idx);
                w_busy  = 1'b1;
              end else if (r_idx == LAST_IDX) begin
                w_state = S_DONE;
                w_done  = 1'b1;
              end else begin
                w_idx   = r_idx + N'(1);
                w_dwell = DWELL_ONE;
                w_dout  = onehot(w_idx);
                w_busy  = 1'b1;
              end
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev_mode <= M_DIRECT;
      r_dout      <= INACTIVE;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_prev_mode <= bus.mode;
      r_dout      <= w_dout;
      r_idx       <= w_idx;
      r_dwell     <= w_dwell;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign bus.dout = r_dout;
  assign bus.idx  = r_idx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios on three configurations
// plus a randomized run against a cycle-level reference model.
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  decoder_seq_if #(.N(2)) bus_a ();
  decoder_seq_if #(.N(3)) bus_b ();
  decoder_seq_if #(.N(2)) bus_c ();

  decoder_seq #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  decoder_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  decoder_seq #(.N(2), .DWELL(2), .ACTIVE_LOW(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.en = 1'b0; bus_a.mode = 2'b00; bus_a.din = '0; bus_a.start = 1'b0;
    bus_b.en = 1'b0; bus_b.mode = 2'b00; bus_b.din = '0; bus_b.start = 1'b0;
    bus_c.en = 1'b0; bus_c.mode = 2'b00; bus_c.din = '0; bus_c.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.en = 1'b1; bus_a.din = 2'd3;
    step();
    n_tests++;
    if (bus_a.dout !== 4'b1000) begin
      n_fail++; $display("FAIL reset_pre_dout: got %b want 1000", bus_a.dout);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== 8'b0) begin
      n_fail++; $display("FAIL reset_async_a: got %b want 00000000",
                         {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done});
    end
    n_tests++;
    if (bus_c.dout !== 4'b1111) begin
      n_fail++; $display("FAIL reset_async_c_polarity: got %b want 1111", bus_c.dout);
    end
    step();
    n_tests++;
    if ({bus_b.dout, bus_b.idx, bus_b.busy, bus_b.done} !== 13'b0) begin
      n_fail++; $display("FAIL reset_hold_b: got %b want 0", {bus_b.dout, bus_b.idx, bus_b.busy, bus_b.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [3:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      bus_a.mode = 2'b00; bus_a.en = 1'b1; bus_a.din = 2'(k);
      step();
      exp_d = 4'b0001 << k;
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {exp_d, 2'(k), 1'b0}) begin
        n_fail++; $display("FAIL direct_en din=%0d: got %b/%0d want %b/%0d", k, bus_a.dout, bus_a.idx, exp_d, k);
      end
      bus_a.en = 1'b0;
      step();
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {4'b0000, 2'(k), 1'b0}) begin
        n_fail++; $display("FAIL direct_dis din=%0d: got %b/%0d want 0000/%0d", k, bus_a.dout, bus_a.idx, k);
      end
    end
  endtask

  task automatic test_sweep_timing();
    logic [7:0] exp_v;
    logic [3:0] d;
    int         ln;
    bus_a.mode = 2'b10; bus_a.en = 1'b1; bus_a.start = 1'b0;
    step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 12) begin
        ln    = (k - 1) / 3;
        d     = 4'b0001 << ln;
        exp_v = {d, 2'(ln), 1'b1, 1'b0};
      end else begin
        exp_v = {4'b0000, 2'd3, 1'b0, 1'b1};
      end
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== exp_v) begin
        n_fail++; $display("FAIL sweep_cycle%0d: got %b want %b", k,
                           {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done}, exp_v);
      end
      if (k == 13) bus_a.start = 1'b1;
      step();
    end
    bus_a.start = 1'b0;
    for (int k = 14; k <= 15; k++) begin
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL sweep_after_done cycle%0d: got %b want 00001100", k,
                           {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done});
      end
      step();
    end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp_d;
    bus_b.mode = 2'b01; bus_b.en = 1'b1;
    step();
    for (int k = 0; k < 18; k++) begin
      exp_d = 8'b00000001 << (k % 8);
      n_tests++;
      if ({bus_b.dout, bus_b.idx, bus_b.busy} !== {exp_d, 3'(k % 8), 1'b1}) begin
        n_fail++; $display("FAIL scan_wrap step%0d: got %b/%0d want %b/%0d", k, bus_b.dout, bus_b.idx, exp_d, k % 8);
      end
      step();
    end
    bus_b.mode = 2'b11;
  endtask

  task automatic test_pause();
    int         n;
    int         ln;
    logic [3:0] d;
    bus_a.mode = 2'b01; bus_a.en = 1'b1;
    step();
    n = 1;
    while (n < 7) begin
      step();
      n++;
    end
    n_tests++;
    if ({bus_a.dout, bus_a.idx} !== {4'b0100, 2'd2}) begin
      n_fail++; $display("FAIL pause_pre: got %b/%0d want 0100/2", bus_a.dout, bus_a.idx);
    end
    bus_a.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {4'b0000, 2'd2, 1'b0}) begin
        n_fail++; $display("FAIL pause_hold%0d: got %b/%0d/%b want 0000/2/0", k, bus_a.dout, bus_a.idx, bus_a.busy);
      end
    end
    bus_a.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n++;
      ln = ((n - 1) / 3) % 4;
      d  = 4'b0001 << ln;
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {d, 2'(ln), 1'b1}) begin
        n_fail++; $display("FAIL pause_resume%0d: got %b/%0d want %b/%0d", k, bus_a.dout, bus_a.idx, d, ln);
      end
    end
  endtask

  task automatic test_abort_ignore();
    bus_a.mode = 2'b10; bus_a.en = 1'b1; bus_a.start = 1'b0;
    step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    n_tests++;
    if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL ignore_start_c3: got %b/%0d want 0001/0", bus_a.dout, bus_a.idx);
    end
    step();
    n_tests++;
    if ({bus_a.dout, bus_a.idx, bus_a.busy} !== {4'b0010, 2'd1, 1'b1}) begin
      n_fail++; $display("FAIL ignore_start_c4: got %b/%0d want 0010/1", bus_a.dout, bus_a.idx);
    end
    bus_a.mode = 2'b00; bus_a.din = 2'd3;
    step();
    n_tests++;
    if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== {4'b1000, 2'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_direct: got %b want 10001100", {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done});
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_tests++;
      if (bus_a.done !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done%0d: got %b want 0", k, bus_a.done);
      end
    end
    bus_a.mode = 2'b10;
    step();
    step();
    n_tests++;
    if ({bus_a.dout, bus_a.busy} !== 5'b0) begin
      n_fail++; $display("FAIL abort_stays_idle: got %b/%b want 0000/0", bus_a.dout, bus_a.busy);
    end
  endtask

  task automatic test_polarity();
    logic [3:0] exp_d;
    int         sel;
    bus_c.mode = 2'b00; bus_c.en = 1'b1; bus_c.din = 2'd0;
    step();
    n_tests++;
    if (bus_c.dout !== 4'b1110) begin
      n_fail++; $display("FAIL polarity_din0: got %b want 1110", bus_c.dout);
    end
    for (int k = 0; k < 8; k++) begin
      sel        = int'($urandom_range(0, 3));
      bus_c.din  = 2'(sel);
      bus_c.en   = (k % 3) != 0;
      step();
      exp_d = bus_c.en ? ~(4'b0001 << sel) : 4'b1111;
      n_tests++;
      if (bus_c.dout !== exp_d) begin
        n_fail++; $display("FAIL polarity_rand%0d: got %b want %b", k, bus_c.dout, exp_d);
      end
    end
    bus_c.mode = 2'b01; bus_c.en = 1'b1;
    step();
    n_tests++;
    if ({bus_c.dout, bus_c.busy} !== {4'b1110, 1'b1}) begin
      n_fail++; $display("FAIL polarity_scan: got %b want 1110", bus_c.dout);
    end
    bus_c.mode = 2'b11;
    step();
    n_tests++;
    if ({bus_c.dout, bus_c.busy} !== {4'b1111, 1'b0}) begin
      n_fail++; $display("FAIL polarity_off: got %b want 1111", bus_c.dout);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus_a.mode = 2'b10; bus_a.en = 1'b1; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== 8'b0) begin
      n_fail++; $display("FAIL reset_mid_sweep: got %b want 00000000", {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done});
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({bus_a.dout, bus_a.busy, bus_a.done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_sweep_idle: got %b want 000000", {bus_a.dout, bus_a.busy, bus_a.done});
    end
  endtask

  // Reference model: scan/sweep positions derived from the count of cycles actually driven.
  task automatic test_random();
    localparam int DW = 3;
    int         prev_mode = 0;
    int         scan_n = 0;
    int         sw_n = 0;
    bit         sw_active = 1'b0;
    bit         done_pend = 1'b0;
    int         e_idx = 0;
    logic [3:0] e_dout;
    logic       e_busy, e_done;
    int         run = 0;
    int         md;
    idle_inputs();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (run == 0) begin
        bus_a.mode = 2'($urandom_range(0, 3));
        run        = int'($urandom_range(1, 30));
      end
      run--;
      bus_a.en    = ($urandom_range(0, 7) != 0);
      bus_a.din   = 2'($urandom_range(0, 3));
      bus_a.start = ($urandom_range(0, 3) == 0);
      step();
      md     = int'(bus_a.mode);
      e_dout = 4'b0000;
      e_busy = 1'b0;
      e_done = 1'b0;
      case (md)
        0: begin
          sw_active = 1'b0; done_pend = 1'b0;
          e_idx = int'(bus_a.din);
          if (bus_a.en) e_dout = 4'b0001 << e_idx;
        end
        1: begin
          sw_active = 1'b0; done_pend = 1'b0;
          if (prev_mode != 1) scan_n = bus_a.en ? 1 : 0;
          else if (bus_a.en) scan_n++;
          e_idx = (scan_n == 0) ? 0 : ((scan_n - 1) / DW) % 4;
          if (bus_a.en) begin e_dout = 4'b0001 << e_idx; e_busy = 1'b1; end
        end
        2: begin
          if (done_pend) begin
            done_pend = 1'b0;
          end else if (sw_active) begin
            if (bus_a.en) begin
              sw_n++;
              if (sw_n > 4 * DW) begin
                sw_active = 1'b0; done_pend = 1'b1; e_done = 1'b1; e_idx = 3;
              end else begin
                e_idx = (sw_n - 1) / DW; e_dout = 4'b0001 << e_idx; e_busy = 1'b1;
              end
            end
          end else if (bus_a.en && bus_a.start) begin
            sw_active = 1'b1; sw_n = 1; e_idx = 0; e_dout = 4'b0001; e_busy = 1'b1;
          end
        end
        default: begin
          sw_active = 1'b0; done_pend = 1'b0;
        end
      endcase
      prev_mode = md;
      n_tests++;
      if ({bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done} !== {e_dout, 2'(e_idx), e_busy, e_done}) begin
        n_fail++; $display("FAIL random cyc%0d mode=%0d: got %b want %b", cyc, md,
                           {bus_a.dout, bus_a.idx, bus_a.busy, bus_a.done}, {e_dout, 2'(e_idx), e_busy, e_done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_sweep_timing();
    test_scan_wrap();
    test_pause();
    test_abort_ignore();
    test_polarity();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
